// File: rtl/td4_ctrl_pkg.sv
// Shared types and constants for the TD4 clock sequencer.
package td4_ctrl_pkg;

    localparam int unsigned RATE_W     = 5;
    localparam int unsigned RATE_MIN   = 1;
    localparam int unsigned STEP_CNT_W = 16;

    typedef enum logic [2:0] {
        HALT     = 3'd0,
        HOLD     = 3'd1,
        RUN_REL  = 3'd2,
        RUN      = 3'd3,
        STOP_REL = 3'd4
    } state_e;

    // Clamp the run period exponent into RATE_MIN..max_rate.
    function automatic logic [RATE_W-1:0] clamp_rate(input logic [RATE_W-1:0] rate,
                                                     input int unsigned       max_rate);
        logic [RATE_W-1:0] r;
        r = rate;
        if (rate < RATE_W'(RATE_MIN)) begin
            r = RATE_W'(RATE_MIN);
        end else if (rate > RATE_W'(max_rate)) begin
            r = RATE_W'(max_rate);
        end
        return r;
    endfunction

endpackage

// File: rtl/td4_step_ctrl_key_debounce.sv
// Key synchronizer and debouncer: 2-flop sync, then a level must hold
// DEB_CYC consecutive cycles before the debounced 'pressed' follows it.
module key_debounce #(
    parameter int unsigned DEB_CYC = 2_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic pressed,
    output logic press_rise,
    output logic press_fall
);

    localparam int unsigned CNT_W = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;

    logic             sync0_q;
    logic             sync1_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             pressed_q;
    logic             pressed_d;
    logic             rise_q;
    logic             rise_d;
    logic             fall_q;
    logic             fall_d;
    logic             level;

    assign level = ~sync1_q;

    // Count consecutive cycles the synced level disagrees with 'pressed'.
    always_comb begin
        cnt_d     = '0;
        pressed_d = pressed_q;
        if (level != pressed_q) begin
            if (cnt_q == CNT_W'(DEB_CYC - 1)) begin
                pressed_d = level;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
        rise_d = pressed_d & ~pressed_q;
        fall_d = ~pressed_d & pressed_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync0_q   <= 1'b1;
            sync1_q   <= 1'b1;
            cnt_q     <= '0;
            pressed_q <= 1'b0;
            rise_q    <= 1'b0;
            fall_q    <= 1'b0;
        end else begin
            sync0_q   <= key_n;
            sync1_q   <= sync0_q;
            cnt_q     <= cnt_d;
            pressed_q <= pressed_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
        end
    end

    assign pressed    = pressed_q;
    assign press_rise = rise_q;
    assign press_fall = fall_q;

endmodule

// File: rtl/td4_step_ctrl.sv
// TD4 CPU clock sequencer: key-driven single step / free-run / halt,
// producing cpu_clk, a step strobe, run status and a step counter.
module td4_step_ctrl
    import td4_ctrl_pkg::*;
#(
    parameter int unsigned DEB_CYC  = 2_000_000,
    parameter int unsigned LONG_CYC = 200_000_000,
    parameter int unsigned DIV_W    = 28
) (
    input  logic                  CLK,
    input  logic                  nRST,
    input  logic                  KEY,
    input  logic [RATE_W-1:0]     rate,
    input  logic                  halt,
    output logic                  cpu_clk,
    output logic                  step_pulse,
    output logic                  running,
    output logic [STEP_CNT_W-1:0] step_cnt
);

    localparam int unsigned HOLD_W = $clog2(LONG_CYC + 1);

    logic pressed;
    logic press_rise;
    logic press_fall;

    key_debounce #(.DEB_CYC(DEB_CYC)) u_key_debounce (
        .clk        (CLK),
        .rst_n      (nRST),
        .key_n      (KEY),
        .pressed    (pressed),
        .press_rise (press_rise),
        .press_fall (press_fall)
    );

    state_e                  state_q, state_d;
    logic [HOLD_W-1:0]       hold_q, hold_d;
    logic [DIV_W-1:0]        phase_q, phase_d;
    logic [RATE_W-1:0]       r_q, r_d;
    logic [DIV_W-1:0]        win_q, win_d;
    logic                    cpu_clk_q, cpu_clk_d;
    logic                    step_pulse_q, step_pulse_d;
    logic [STEP_CNT_W-1:0]   step_cnt_q, step_cnt_d;
    logic                    req_q, req_d;
    logic                    running_q, running_d;

    logic [RATE_W-1:0]       rate_c;
    logic                    in_run;
    logic                    wrap;
    logic [DIV_W-1:0]        period_max;

    assign rate_c     = clamp_rate(rate, DIV_W - 1);
    assign in_run     = (state_q == RUN) || (state_q == RUN_REL);
    assign period_max = (DIV_W'(1) << r_q) - DIV_W'(1);
    assign wrap       = in_run && (phase_q == period_max);

    // Mode FSM and single-step request.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        req_d   = 1'b0;
        case (state_q)
            HALT: begin
                if (press_rise) begin
                    state_d = HOLD;
                    hold_d  = '0;
                end
            end
            HOLD: begin
                if (hold_q != HOLD_W'(LONG_CYC)) begin
                    hold_d = hold_q + HOLD_W'(1);
                end
                if (press_fall) begin
                    req_d   = (hold_q < HOLD_W'(LONG_CYC)) && !halt;
                    state_d = HALT;
                end else if ((hold_d == HOLD_W'(LONG_CYC)) && !halt) begin
                    state_d = RUN_REL;
                end
            end
            RUN_REL: begin
                if (halt) begin
                    state_d = pressed ? STOP_REL : HALT;
                end else if (press_fall) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (halt) begin
                    state_d = pressed ? STOP_REL : HALT;
                end else if (press_rise) begin
                    state_d = STOP_REL;
                end
            end
            STOP_REL: begin
                if (press_fall) begin
                    state_d = HALT;
                end
            end
            default: state_d = HALT;
        endcase
    end

    // Phase divider, step strobe, cpu_clk high window and step counter.
    always_comb begin
        phase_d      = phase_q;
        r_d          = r_q;
        cpu_clk_d    = cpu_clk_q;
        win_d        = win_q;
        step_pulse_d = 1'b0;
        step_cnt_d   = step_cnt_q;

        if ((state_q == HOLD) && (state_d == RUN_REL)) begin
            phase_d = '0;
            r_d     = rate_c;
        end else if (wrap) begin
            phase_d = '0;
            r_d     = rate_c;
        end else if (in_run) begin
            phase_d = phase_q + DIV_W'(1);
        end

        // A step request landing inside an active high window is dropped.
        step_pulse_d = wrap || (req_q && !cpu_clk_q);

        if (step_pulse_d) begin
            cpu_clk_d  = 1'b1;
            win_d      = (DIV_W'(1) << (rate_c - RATE_W'(1))) - DIV_W'(1);
            step_cnt_d = step_cnt_q + STEP_CNT_W'(1);
        end else if (cpu_clk_q) begin
            if (win_q == '0) begin
                cpu_clk_d = 1'b0;
            end else begin
                win_d = win_q - DIV_W'(1);
            end
        end

        running_d = (state_d == RUN) || (state_d == RUN_REL);
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q      <= HALT;
            hold_q       <= '0;
            phase_q      <= '0;
            r_q          <= RATE_W'(RATE_MIN);
            win_q        <= '0;
            cpu_clk_q    <= 1'b0;
            step_pulse_q <= 1'b0;
            step_cnt_q   <= '0;
            req_q        <= 1'b0;
            running_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            phase_q      <= phase_d;
            r_q          <= r_d;
            win_q        <= win_d;
            cpu_clk_q    <= cpu_clk_d;
            step_pulse_q <= step_pulse_d;
            step_cnt_q   <= step_cnt_d;
            req_q        <= req_d;
            running_q    <= running_d;
        end
    end

    assign cpu_clk    = cpu_clk_q;
    assign step_pulse = step_pulse_q;
    assign running    = running_q;
    assign step_cnt   = step_cnt_q;

endmodule

// File: tb/tb_td4_step_ctrl.sv
// Scoreboard bench for td4_step_ctrl: an event/timestamp reference model
// predicts every cycle's outputs, a separate monitor compares them.
module tb_td4_step_ctrl;

    localparam int DEB  = 4;
    localparam int LONG = 64;
    localparam int DW   = 28;

    localparam int M_HALT     = 0;
    localparam int M_HOLD     = 1;
    localparam int M_RUN_REL  = 2;
    localparam int M_RUN      = 3;
    localparam int M_STOP_REL = 4;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        KEY;
    logic [4:0]  rate;
    logic        halt;
    logic        cpu_clk;
    logic        step_pulse;
    logic        running;
    logic [15:0] step_cnt;

    td4_step_ctrl #(.DEB_CYC(DEB), .LONG_CYC(LONG), .DIV_W(DW)) dut (
        .CLK        (CLK),
        .nRST       (nRST),
        .KEY        (KEY),
        .rate       (rate),
        .halt       (halt),
        .cpu_clk    (cpu_clk),
        .step_pulse (step_pulse),
        .running    (running),
        .step_cnt   (step_cnt)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic        pulse;
        logic        cpu;
        logic        run;
        logic [15:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // Reference model state: edge-count timestamps instead of counters.
    int n, st, hs, next_wrap, cpu_end, cnt;
    bit pressed_m, rise_m, fall_m, req_m, k1, k2;
    bit lvl_hist[$];

    task automatic model_reset();
        n = 0; st = M_HALT; hs = 0; next_wrap = 0; cpu_end = 0; cnt = 0;
        pressed_m = 0; rise_m = 0; fall_m = 0; req_m = 0; k1 = 1; k2 = 1;
        lvl_hist.delete();
    endtask

    task automatic model_edge();
        exp_t e;
        bit   lvl, o_rise, o_fall, o_pressed, o_req, pulse, same;
        int   o_st, rc;
        if (!nRST) begin
            model_reset();
            exp_q.push_back('0);
            return;
        end
        n++;
        o_rise = rise_m; o_fall = fall_m; o_pressed = pressed_m; o_req = req_m; o_st = st;
        rc = (int'(rate) < 1) ? 1 : ((int'(rate) > DW - 1) ? DW - 1 : int'(rate));

        // debounced level follows only after DEB identical synced samples
        lvl = !k2;
        k2 = k1;
        k1 = KEY;
        lvl_hist.push_back(lvl);
        if (lvl_hist.size() > DEB) void'(lvl_hist.pop_front());
        rise_m = 0; fall_m = 0;
        if (lvl_hist.size() == DEB) begin
            same = 1;
            for (int i = 0; i < DEB; i++) if (lvl_hist[i] == pressed_m) same = 0;
            if (same) begin
                pressed_m = !pressed_m;
                rise_m = pressed_m;
                fall_m = !pressed_m;
            end
        end

        req_m = 0;
        pulse = 0;
        case (o_st)
            M_HALT: if (o_rise) begin st = M_HOLD; hs = n; end
            M_HOLD: begin
                if (o_fall) begin
                    req_m = ((n - 1 - hs) < LONG) && !halt;
                    st = M_HALT;
                end else if ((n - hs) >= LONG && !halt) begin
                    st = M_RUN_REL;
                    next_wrap = n + (1 << rc);
                end
            end
            M_RUN_REL: begin
                if (halt) st = o_pressed ? M_STOP_REL : M_HALT;
                else if (o_fall) st = M_RUN;
            end
            M_RUN: begin
                if (halt) st = o_pressed ? M_STOP_REL : M_HALT;
                else if (o_rise) st = M_STOP_REL;
            end
            M_STOP_REL: if (o_fall) st = M_HALT;
            default: st = M_HALT;
        endcase

        if ((o_st == M_RUN || o_st == M_RUN_REL) && n == next_wrap) begin
            pulse = 1;
            next_wrap = n + (1 << rc);
        end
        if (o_req && !((n - 1) < cpu_end)) pulse = 1;
        if (pulse) begin
            cpu_end = n + (1 << (rc - 1));
            cnt = (cnt + 1) % 65536;
        end

        e.pulse = pulse;
        e.cpu   = (n < cpu_end);
        e.run   = (st == M_RUN || st == M_RUN_REL);
        e.cnt   = 16'(cnt);
        exp_q.push_back(e);
    endtask

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s t=%0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge CLK);
            model_edge();
        end
    end

    // Monitor: one expected record per clock, compared on the falling edge.
    initial begin
        exp_t e;
        @(posedge CLK);
        forever begin
            @(negedge CLK);
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL scoreboard_empty t=%0t: got 0 entries, expected 1", $time);
            end else begin
                e = exp_q.pop_front();
                if (!nRST) e = '0;
                check("step_pulse", int'(step_pulse), int'(e.pulse));
                check("cpu_clk",    int'(cpu_clk),    int'(e.cpu));
                check("running",    int'(running),    int'(e.run));
                check("step_cnt",   int'(step_cnt),   int'(e.cnt));
            end
        end
    end

    task automatic cycles(input int k);
        repeat (k) @(negedge CLK);
    endtask

    task automatic press(input int len);
        KEY = 1'b0;
        cycles(len);
        KEY = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog t=%0t: got timeout, expected finish", $time);
        $fatal(1);
    end

    initial begin
        int a, b;
        KEY = 1'b1; halt = 1'b0; rate = 5'd3; nRST = 1'b0;
        cycles(5);
        nRST = 1'b1;
        cycles(5);

        // short press: one step, 4-cycle high window
        press(20);
        cycles(40);

        // bouncing key never settles for DEB cycles
        repeat (15) begin
            KEY = ~KEY;
            cycles(2);
        end
        KEY = 1'b1;
        cycles(20);

        // long press into free run, about ten periods
        press(100);
        cycles(90);

        // press in run halts, then a short press steps once
        press(10);
        cycles(20);
        press(20);
        cycles(30);

        // run again, then a one-cycle halt with key released
        press(100);
        cycles(30);
        halt = 1'b1;
        cycles(1);
        halt = 1'b0;
        cycles(30);

        // rate change mid-period, then reset mid-run
        press(100);
        cycles(13);
        rate = 5'd1;
        cycles(20);
        @(posedge CLK);
        #1 nRST = 1'b0;
        #1;
        check("rst_cpu_clk",    int'(cpu_clk),    0);
        check("rst_step_pulse", int'(step_pulse), 0);
        check("rst_running",    int'(running),    0);
        check("rst_step_cnt",   int'(step_cnt),   0);
        cycles(3);
        nRST = 1'b1;
        cycles(10);

        // randomized presses, rates (including clamp at 0) and halts
        repeat (30) begin
            case ($urandom_range(0, 4))
                0: begin
                    press(int'($urandom_range(1, 110)));
                    cycles(int'($urandom_range(5, 40)));
                end
                1: rate = 5'($urandom_range(0, 4));
                2: begin
                    halt = 1'b1;
                    cycles(int'($urandom_range(1, 3)));
                    halt = 1'b0;
                    cycles(int'($urandom_range(1, 20)));
                end
                3: cycles(int'($urandom_range(1, 30)));
                default: begin
                    a = int'($urandom_range(5, 90));
                    b = int'($urandom_range(1, 30));
                    KEY = 1'b0;
                    cycles(a);
                    halt = 1'b1;
                    cycles(1);
                    halt = 1'b0;
                    cycles(b);
                    KEY = 1'b1;
                    cycles(20);
                end
            endcase
        end
        cycles(40);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/td4_step_ctrl.md
# td4_step_ctrl

Clock sequencer for the TD4 CPU core on the Tang Nano board. It replaces the free-running divided-counter clock with a controlled one. It debounces the single user key and classifies each press:
- short press in halt: issue exactly one CPU step
- long press in halt: enter free-run
- any press in run: halt

It drives the CPU clock and a one-cycle step strobe, and exports run status and a step count for the LCD register display.

## Interface
Parameters:
- DEB_CYC, 2_000_000: stable cycles required to accept a key level change (10 ms at 200 MHz).
- LONG_CYC, 200_000_000: hold cycles that make a press "long" (1 s).
- DIV_W, 28: width of the run-mode phase divider.

Ports:
- CLK  in  1  system clock (200 MHz PLL output); the only clock.
- nRST  in  1  reset, asynchronous assert, active-low; the only reset.
- KEY  in  1  raw push-button, active-low, asynchronous to CLK.
- rate  in  5  run period exponent; period = 2^rate CLK cycles; clamped to 1..DIV_W-1.
- halt  in  1  synchronous level; forces halt from any run state.
- cpu_clk  out  1  CPU clock level to td4_logic; reset 0.
- step_pulse  out  1  one-CLK strobe coincident with each cpu_clk rising edge; reset 0.
- running  out  1  high in RUN and RUN_REL; reset 0.
- step_cnt  out  16  steps issued since reset, wraps 0xFFFF to 0; reset 0.

## Operation
- KEY passes a 2-flop synchronizer, then the debouncer. Debounced level `pressed` changes only after the synchronized KEY has held the new level for DEB_CYC consecutive cycles. `pressed` resets to 0.
- Press edge (`press_rise`) and release edge (`press_fall`) are one-cycle strobes derived from `pressed`.
- FSM states, reset state HALT:
  - HALT: running=0. On press_rise, clear hold_cnt and go to HOLD.
  - HOLD: hold_cnt increments and saturates at LONG_CYC.
    - press_fall with hold_cnt < LONG_CYC: request one step, go to HALT.
    - hold_cnt reaches LONG_CYC: go to RUN_REL and clear the divider.
  - RUN_REL: running=1, free-run active, key ignored. On press_fall, go to RUN.
  - RUN: running=1. On press_rise, go to STOP_REL.
  - STOP_REL: running=0. On press_fall, go to HALT.
- halt=1 while in RUN or RUN_REL: go to STOP_REL if pressed=1, otherwise to HALT. halt=1 while in HOLD: the press still completes, but a resulting step request is dropped and a long press does not enter run.
- Divider:
  - phase counts 0 to 2^r-1, where r is the clamped rate, latched at each wrap and on entry to RUN_REL.
  - In run states, phase wraps every 2^r cycles, and step_pulse fires on each wrap.
  - The first step_pulse comes 2^r cycles after entering RUN_REL.
- Single step: the request fires step_pulse the next cycle, but only if the cpu_clk high window is idle. A request that arrives while cpu_clk is high is dropped.
- cpu_clk rises with step_pulse and stays high for 2^(r-1) cycles. Leaving run mid-window does not truncate the window.
- step_cnt increments on every step_pulse.

## Timing
- KEY to `pressed`: 2 sync cycles + DEB_CYC cycles.
- Short press: step_pulse 1 cycle after the HOLD-to-HALT transition.
- Long press: RUN_REL entered on the cycle hold_cnt == LONG_CYC.
- Mid-operation reset: all outputs drop to reset values immediately; the FSM returns to HALT; the debouncer restarts.
- A rate change takes effect at the next wrap, never mid-period.

## Structure
- Package td4_ctrl_pkg holds:
  - FSM state encoding (HALT, HOLD, RUN_REL, RUN, STOP_REL)
  - RATE_MIN = 1
  - step_cnt width of 16
- One sub-module, key_debounce: synchronizer plus stable counter. Parameter DEB_CYC; outputs pressed, press_rise, press_fall.
- Top-level wiring: CLOCK of td4_logic takes cpu_clk; the LCD register selector may display step_cnt[3:0] and running.

## Test plan
Bench parameters: DEB_CYC=4, LONG_CYC=64, rate=3.
- KEY low for 20 cycles then high, from HALT -> exactly one step_pulse, cpu_clk high 4 cycles, step_cnt=1, running stays 0.
- KEY bouncing (toggling every 2 cycles for 30 cycles) then stable high -> no step_pulse, state remains HALT.
- KEY low for 100 cycles -> running=1 at hold 64, then step_pulse every 8 cycles; after 10 periods step_cnt=10.
- In RUN, press 10 cycles and release -> running=0 at debounced press, step_pulse stops, FSM in HALT after release; the next short press gives one step.
- In RUN, assert halt=1 for one cycle with key released -> HALT next cycle; in-flight cpu_clk window completes; no further pulses.
- In RUN, rate 3->1 mid-period -> current 8-cycle period completes, then 2-cycle periods; nRST low mid-run -> all outputs 0 the same cycle, step_cnt=0.
